tile_map_writer: RTL
====================

TILE_MAP_WRITER -- requirements
Module: tile_map_writer

Interface
REQ-001 SHALL: parameters: COLS default 80, tile columns per row; ROWS default 60, tile rows; MAX_ID default 40, highest legal tile ID.
REQ-002 SHALL: clk  in  1  single clock domain, rising edge.
REQ-003 SHALL: reset_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL: chipselect  in  1  host select; write  in  1; read  in  1; address  in  3  register index; writedata  in  16.
REQ-005 SHALL: readdata  out  16  register read value; waitrequest  out  1  host write stall.
REQ-006 SHALL: tile_we  out  1  tile RAM write strobe; tile_addr  out  13  tile index y*COLS+x; tile_data  out  6  tile ID; busy  out  1  engine active.

Function
REQ-007 SHALL: registers are 0 POS (x=[6:0], y=[13:8]), 1 TILE (id=[5:0], write triggers a single store), 2 SIZE (w=[6:0], h=[13:8], 1-based), 3 CMD (bit0 FILL, bit1 CLEAR), 4 STATUS (bit0 busy, bit1 err sticky; writing 1 to bit1 clears err).
REQ-008 SHALL: a host access is accepted when chipselect is high and waitrequest is low.
REQ-009 SHALL: the FSM has states IDLE, SINGLE, FILL and CLEAR; busy is high in every state except IDLE.
REQ-010 SHALL: an accepted TILE write in IDLE latches id, enters SINGLE, and asserts tile_we for exactly one cycle on the next edge with tile_addr=y*COLS+x; it then returns to IDLE.
REQ-011 SHALL: after a single store, POS auto-increments: x+1; at x=COLS-1, x wraps to 0 and y increments; at (COLS-1, ROWS-1), POS wraps to (0,0).
REQ-012 SHALL: FILL, triggered by CMD bit0, writes the latched TILE id row-major over the rectangle from POS, one tile per cycle; the rectangle is clipped at x=COLS-1 and y=ROWS-1; POS is unchanged afterwards.
REQ-013 SHALL: CLEAR, triggered by CMD bit1, writes 0 to addresses 0..COLS*ROWS-1 in ascending order, one per cycle, i.e. 4800 cycles at default parameters.
REQ-014 SHALL: if CMD bits 0 and 1 are both set, CLEAR executes and FILL is ignored.
REQ-015 SHALL: waitrequest is high for writes to TILE or CMD while busy, and low otherwise; POS, SIZE and STATUS writes never stall, even during an operation.
REQ-016 SHALL: a POS or SIZE write during FILL does not disturb the running fill, which uses values latched at start.
REQ-017 SHALL: reads never stall; readdata is registered, with fixed read latency 1; unused bits and addresses 5-7 read 0.
REQ-018 SHALL: a TILE id > MAX_ID sets err and no store occurs.
REQ-019 SHALL: a POS write with x >= COLS or y >= ROWS sets err and leaves POS unchanged.
REQ-020 SHALL: FILL with w=0 or h=0 sets err and performs no store.
REQ-021 SHALL: tile_we is high only in SINGLE, FILL or CLEAR write cycles; tile_addr and tile_data are held stable while tile_we is high.
REQ-022 SHALL: tile_addr is computed in 13-bit unsigned arithmetic and never exceeds COLS*ROWS-1.

Reset
REQ-023 SHALL: on reset_n low: state=IDLE, POS=(0,0), TILE=0, SIZE=(0,0), err=0, tile_we=0, busy=0, waitrequest=0, readdata=0, tile_addr=0, tile_data=0.
REQ-024 SHALL: reset asserted mid-FILL or mid-CLEAR aborts the operation immediately; tile_we falls asynchronously and no further stores occur.
REQ-025 SHALL: after reset_n rises, the first host access is accepted on the first clock edge.

Verification
REQ-026 SHALL: POS=(79,59), TILE=12 -> one tile_we with addr 4799, data 12; STATUS then reads busy=0; POS reads (0,0).
REQ-027 SHALL: POS=(78,10), SIZE=(4,2), TILE=7 written while idle, then CMD=1 -> 4 stores total: addr 878, 879, 958, 959; POS remains (78,10).
REQ-028 SHALL: CMD=3 -> 4800 stores of data 0, addr 0..4799, busy high throughout; a TILE write issued during CLEAR sees waitrequest high until IDLE and completes afterwards.
REQ-029 SHALL: TILE=41 -> no tile_we and err=1; writing STATUS=0x2 -> err=0.
REQ-030 SHALL: reset_n pulsed low during a FILL at cycle 3 -> tile_we=0 at once and all registers at reset values; then POS=(0,0), TILE=5 -> one store at addr 0, data 5.

Source files
------------

// File: rtl/tile_map_writer.sv
// Host-programmed tile map writer: single stores, rectangle fill and full clear into a tile RAM.
// Latency: one cycle from accepted TILE/CMD write to first tile_we; readdata one cycle after read.
// Backpressure: waitrequest stalls TILE/CMD writes while busy; POS/SIZE/STATUS writes and reads never stall.
module tile_map_writer #(
    parameter int COLS   = 80,
    parameter int ROWS   = 60,
    parameter int MAX_ID = 40
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        chipselect,
    input  logic        write,
    input  logic        read,
    input  logic [2:0]  address,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        waitrequest,
    output logic        tile_we,
    output logic [12:0] tile_addr,
    output logic [5:0]  tile_data,
    output logic        busy
);

    localparam logic [12:0] LAST_ADDR = 13'(COLS * ROWS - 1);
    localparam logic [12:0] COLS13    = 13'(COLS);
    localparam logic [6:0]  X_MAX     = 7'(COLS - 1);
    localparam logic [5:0]  Y_MAX     = 6'(ROWS - 1);
    localparam logic [5:0]  ID_MAX    = 6'(MAX_ID);

    typedef enum logic [1:0] {S_IDLE, S_SINGLE, S_FILL, S_CLEAR} state_t;

    state_t      state_q, state_d;
    logic [6:0]  pos_x_q, pos_x_d;
    logic [5:0]  pos_y_q, pos_y_d;
    logic [5:0]  tile_id_q, tile_id_d;
    logic [6:0]  size_w_q, size_w_d;
    logic [5:0]  size_h_q, size_h_d;
    logic        err_q, err_d;
    logic [6:0]  cur_x_q, cur_x_d;
    logic [5:0]  cur_y_q, cur_y_d;
    logic [6:0]  x_lo_q, x_lo_d;
    logic [6:0]  x_hi_q, x_hi_d;
    logic [5:0]  y_hi_q, y_hi_d;
    logic        tile_we_q, tile_we_d;
    logic [12:0] tile_addr_q, tile_addr_d;
    logic [5:0]  tile_data_q, tile_data_d;
    logic [15:0] readdata_q, readdata_d;

    logic        wr_acc;
    logic        rd_acc;
    logic [7:0]  x_end;
    logic [6:0]  y_end;
    logic        unused_bits;

    function automatic logic [12:0] addr_of(input logic [6:0] x, input logic [5:0] y);
        return 13'(y) * COLS13 + 13'(x);
    endfunction

    assign busy        = (state_q != S_IDLE);
    assign waitrequest = chipselect & write & busy & ((address == 3'd1) | (address == 3'd3));
    assign wr_acc      = chipselect & write & ~waitrequest;
    assign rd_acc      = chipselect & read;
    assign tile_we     = tile_we_q;
    assign tile_addr   = tile_addr_q;
    assign tile_data   = tile_data_q;
    assign readdata    = readdata_q;
    assign unused_bits = ^{writedata[15:14], writedata[7]};

    // Fill rectangle corner, clipped to the map edge (only used when w,h >= 1).
    assign x_end = {1'b0, pos_x_q} + {1'b0, size_w_q} - 8'd1;
    assign y_end = {1'b0, pos_y_q} + {1'b0, size_h_q} - 7'd1;

    // Next-state: engine sequencing, host register writes and registered read data.
    always_comb begin
        state_d     = state_q;
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        tile_id_d   = tile_id_q;
        size_w_d    = size_w_q;
        size_h_d    = size_h_q;
        err_d       = err_q;
        cur_x_d     = cur_x_q;
        cur_y_d     = cur_y_q;
        x_lo_d      = x_lo_q;
        x_hi_d      = x_hi_q;
        y_hi_d      = y_hi_q;
        tile_we_d   = 1'b0;
        tile_addr_d = tile_addr_q;
        tile_data_d = tile_data_q;
        readdata_d  = readdata_q;

        case (state_q)
            S_IDLE: begin
                if (wr_acc && address == 3'd1) begin
                    if (writedata[5:0] > ID_MAX) begin
                        err_d = 1'b1;
                    end else begin
                        tile_id_d   = writedata[5:0];
                        state_d     = S_SINGLE;
                        tile_we_d   = 1'b1;
                        tile_addr_d = addr_of(pos_x_q, pos_y_q);
                        tile_data_d = writedata[5:0];
                        // Cursor advances as soon as the store is committed.
                        if (pos_x_q == X_MAX) begin
                            pos_x_d = 7'd0;
                            pos_y_d = (pos_y_q == Y_MAX) ? 6'd0 : pos_y_q + 6'd1;
                        end else begin
                            pos_x_d = pos_x_q + 7'd1;
                        end
                    end
                end else if (wr_acc && address == 3'd3) begin
                    if (writedata[1]) begin
                        state_d     = S_CLEAR;
                        tile_we_d   = 1'b1;
                        tile_addr_d = 13'd0;
                        tile_data_d = 6'd0;
                    end else if (writedata[0]) begin
                        if (size_w_q == 7'd0 || size_h_q == 6'd0) begin
                            err_d = 1'b1;
                        end else begin
                            state_d     = S_FILL;
                            cur_x_d     = pos_x_q;
                            cur_y_d     = pos_y_q;
                            x_lo_d      = pos_x_q;
                            x_hi_d      = (x_end > {1'b0, X_MAX}) ? X_MAX : x_end[6:0];
                            y_hi_d      = (y_end > {1'b0, Y_MAX}) ? Y_MAX : y_end[5:0];
                            tile_we_d   = 1'b1;
                            tile_addr_d = addr_of(pos_x_q, pos_y_q);
                            tile_data_d = tile_id_q;
                        end
                    end
                end
            end
            S_SINGLE: begin
                state_d = S_IDLE;
            end
            S_FILL: begin
                if (cur_x_q == x_hi_q && cur_y_q == y_hi_q) begin
                    state_d = S_IDLE;
                end else begin
                    if (cur_x_q == x_hi_q) begin
                        cur_x_d = x_lo_q;
                        cur_y_d = cur_y_q + 6'd1;
                    end else begin
                        cur_x_d = cur_x_q + 7'd1;
                    end
                    tile_we_d   = 1'b1;
                    tile_addr_d = addr_of(cur_x_d, cur_y_d);
                end
            end
            S_CLEAR: begin
                if (tile_addr_q == LAST_ADDR) begin
                    state_d = S_IDLE;
                end else begin
                    tile_we_d   = 1'b1;
                    tile_addr_d = tile_addr_q + 13'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Non-stalling registers; a running fill works from its own latched copies.
        if (wr_acc && address == 3'd0) begin
            if (writedata[6:0] > X_MAX || writedata[13:8] > Y_MAX) begin
                err_d = 1'b1;
            end else begin
                pos_x_d = writedata[6:0];
                pos_y_d = writedata[13:8];
            end
        end
        if (wr_acc && address == 3'd2) begin
            size_w_d = writedata[6:0];
            size_h_d = writedata[13:8];
        end
        if (wr_acc && address == 3'd4 && writedata[1]) begin
            err_d = 1'b0;
        end

        if (rd_acc) begin
            case (address)
                3'd0:    readdata_d = {2'b0, pos_y_q, 1'b0, pos_x_q};
                3'd1:    readdata_d = {10'b0, tile_id_q};
                3'd2:    readdata_d = {2'b0, size_h_q, 1'b0, size_w_q};
                3'd4:    readdata_d = {14'b0, err_q, busy};
                default: readdata_d = 16'd0;
            endcase
        end
    end

    // State and register file; reset aborts any operation and drops tile_we at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            pos_x_q     <= 7'd0;
            pos_y_q     <= 6'd0;
            tile_id_q   <= 6'd0;
            size_w_q    <= 7'd0;
            size_h_q    <= 6'd0;
            err_q       <= 1'b0;
            cur_x_q     <= 7'd0;
            cur_y_q     <= 6'd0;
            x_lo_q      <= 7'd0;
            x_hi_q      <= 7'd0;
            y_hi_q      <= 6'd0;
            tile_we_q   <= 1'b0;
            tile_addr_q <= 13'd0;
            tile_data_q <= 6'd0;
            readdata_q  <= 16'd0;
        end else begin
            state_q     <= state_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            tile_id_q   <= tile_id_d;
            size_w_q    <= size_w_d;
            size_h_q    <= size_h_d;
            err_q       <= err_d;
            cur_x_q     <= cur_x_d;
            cur_y_q     <= cur_y_d;
            x_lo_q      <= x_lo_d;
            x_hi_q      <= x_hi_d;
            y_hi_q      <= y_hi_d;
            tile_we_q   <= tile_we_d;
            tile_addr_q <= tile_addr_d;
            tile_data_q <= tile_data_d;
            readdata_q  <= readdata_d;
        end
    end

endmodule
